// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: log2 sizing function and the
// pointer/count width derivation for the default geometry.
package fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = clog2(DEPTH_DEF);
  localparam int PTR_W_DEF  = ptr_width(DEPTH_DEF);
  localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage with a synchronous write port and a registered
// read port; the array itself is never reset, only the read register is.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, level flags and sticky
// error flags around a fifo_mem array, with flush taking priority over traffic.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = 6,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_accept;
  logic             rd_accept;

  // Handshake: a request (wr_en / rd_en) is a one-cycle enable with no
  // back-pressure wait; it is either accepted on that edge or dropped and
  // recorded in the sticky flag. Reads never bypass an empty FIFO, while a
  // write into a full FIFO is accepted when a read frees a slot on the same edge.
  assign rd_accept = rd_en && !empty && !flush;
  assign wr_accept = wr_en && !flush && (!full || rd_accept);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_accept) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_accept && !rd_accept) begin
        count <= count + CNT_ONE;
      end else if (rd_accept && !wr_accept) begin
        count <= count - CNT_ONE;
      end
      if (wr_en && !wr_accept) overflow  <= 1'b1;
      if (rd_en && !rd_accept) underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_accept),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (rd_accept),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: a vector table with expected
// occupancy/sticky flags, a reference queue feeding an expected read-data queue.
module tb_sync_fifo_ctrl;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 8;
  localparam int AFULL_LVL  = 6;
  localparam int AEMPTY_LVL = 2;

  typedef struct {
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    int                exp_count;
    logic              exp_ovf;
    logic              exp_unf;
  } vec_t;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [3:0]        count;
  logic              overflow;
  logic              underflow;

  sync_fifo_ctrl #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // scoreboard state
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] last_rd;
  vec_t              vecs[$];
  int                checks;
  int                errors;

  function automatic void add(input logic f, input logic w, input logic [DATA_W-1:0] d,
                              input logic r, input int cnt, input logic ovf, input logic unf);
    vec_t v;
    v.flush     = f;
    v.wr_en     = w;
    v.wr_data   = d;
    v.rd_en     = r;
    v.exp_count = cnt;
    v.exp_ovf   = ovf;
    v.exp_unf   = unf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: applies inputs and advances the reference model for this edge
  task automatic drive(input vec_t v, output bit rd_ok);
    bit wr_ok;
    flush   = v.flush;
    wr_en   = v.wr_en;
    wr_data = v.wr_data;
    rd_en   = v.rd_en;
    rd_ok = v.rd_en && !v.flush && (model_q.size() > 0);
    wr_ok = v.wr_en && !v.flush && ((model_q.size() < DEPTH) || rd_ok);
    if (v.flush) model_q.delete();
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(v.wr_data);
  endtask

  task automatic check_out(input string tag, input vec_t v, input bit rd_ok);
    logic [DATA_W-1:0] exp_d;
    chk({tag, " count"}, 32'(count), 32'(v.exp_count));
    chk({tag, " full"}, 32'(full), 32'(v.exp_count == DEPTH));
    chk({tag, " empty"}, 32'(empty), 32'(v.exp_count == 0));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(v.exp_count >= AFULL_LVL));
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'(v.exp_count <= AEMPTY_LVL));
    chk({tag, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(v.exp_unf));
    if (rd_ok) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s rd_data: scoreboard empty", tag);
      end else begin
        exp_d = exp_q.pop_front();
        last_rd = exp_d;
        chk({tag, " rd_data"}, 32'(rd_data), 32'(exp_d));
      end
    end else begin
      chk({tag, " rd_data_hold"}, 32'(rd_data), 32'(last_rd));
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit rd_ok;
    @(negedge clk);
    drive(v, rd_ok);
    @(posedge clk);
    #1;
    check_out(tag, v, rd_ok);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " empty"}, 32'(empty), 32'd1);
    chk({tag, " almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
    chk({tag, " underflow"}, 32'(underflow), 32'd0);
    chk({tag, " rd_data"}, 32'(rd_data), 32'd0);
  endtask

  initial begin
    vec_t v;
    bit   rd_ok;
    checks  = 0;
    errors  = 0;
    last_rd = '0;
    rst     = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;

    // fill to full, overflow, write-with-read on full, drain in order
    for (int i = 0; i < 8; i++) add(0, 1, 8'((i + 1) * 17), 0, i + 1, 0, 0);
    add(0, 1, 8'hEE, 0, 8, 1, 0);
    add(0, 1, 8'h99, 1, 8, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 1, 7 - i, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    // read on empty with concurrent write: no bypass
    add(0, 1, 8'h5A, 1, 1, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 1);
    // interleaved single write/read long enough to wrap the pointers
    for (int i = 0; i < 20; i++) begin
      add(0, 1, 8'(8'h20 + i), 0, 1, 0, 1);
      add(0, 0, 8'h00, 1, 0, 0, 1);
    end
    // flush with count 5 and simultaneous requests
    for (int i = 0; i < 5; i++) add(0, 1, 8'(8'h40 + i), 0, i + 1, 0, 1);
    add(1, 1, 8'hFF, 1, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 8'h61, 0, 1, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 0);

    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // asynchronous reset mid-cycle with three words stored
    for (int i = 0; i < 3; i++) begin
      add(0, 1, 8'(8'hA1 + i), 0, i + 1, 0, 0);
      run_vec($sformatf("pre_rst%0d", i), vecs[vecs.size() - 1]);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    model_q.delete();
    exp_q.delete();
    last_rd = '0;
    #1 rst = 1'b0;
    add(0, 1, 8'hB1, 0, 1, 0, 0);
    v = vecs[vecs.size() - 1];
    drive(v, rd_ok);
    @(posedge clk);
    #1 check_out("post_rst_wr", v, rd_ok);
    add(0, 0, 8'h00, 1, 0, 0, 0);
    run_vec("post_rst_rd", vecs[vecs.size() - 1]);

    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
